// File: rtl/count_sequencer.sv
// Run controller for the COUNT event-counter datapath: samples event pins,
// latches the counting mode, owns the count register and sequences one window.
module count_sequencer #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned WCNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic [1:0] mode_sel,
    input  logic       A_in,
    input  logic       B_in,
    input  logic       C_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic [1:0] mode,
    output logic [1:0] state,
    output logic [7:0] CountIn,
    input  logic [7:0] CountOut,
    output logic [7:0] count,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic              c_q, c_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        state_c;
    logic              saturate_c;

    // State register and all datapath flops; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            mode_q  <= 2'b00;
            count_q <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update; abort overrides everything else.
    always_comb begin
        fsm_d   = fsm_q;
        a_d     = A_in;
        b_d     = B_in;
        c_d     = C_in;
        mode_d  = mode_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q;

        // Count gate seen by COUNT: only a non-paused, non-aborted RUN cycle.
        state_c    = ((fsm_q == S_RUN) && !pause && !abort) ? 2'b01 : 2'b00;
        saturate_c = (count_q == {CNT_W{1'b1}}) && (CountOut == '0);

        if (abort) begin
            fsm_d   = S_IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
            wcnt_d  = '0;
        end else begin
            case (fsm_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_d  = mode_sel;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        wcnt_d  = WCNT_W'(WINDOW);
                        fsm_d   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        fsm_d = S_PAUSE;
                    end else begin
                        wcnt_d = wcnt_q - WCNT_W'(1);
                        // A wrap from 255 to 0 ends the window early with count held.
                        if (saturate_c) begin
                            ovf_d = 1'b1;
                            fsm_d = S_DONE;
                        end else begin
                            count_d = CountOut;
                            if (wcnt_q == WCNT_W'(1)) begin
                                fsm_d = S_DONE;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        fsm_d = S_RUN;
                    end
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end

        busy_d = (fsm_d == S_RUN) || (fsm_d == S_PAUSE);
        done_d = (fsm_d == S_DONE);
    end

    assign A       = a_q;
    assign B       = b_q;
    assign C       = c_q;
    assign mode    = mode_q;
    assign state   = state_c;
    assign CountIn = count_q;
    assign count   = count_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: two instances (WINDOW=8 and 300),
// each paired with a behavioural COUNT model; results checked when done rises.
module tb_count_sequencer;

    typedef struct packed {
        logic [7:0]  cnt;
        logic        ovf;
        logic [31:0] done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic       start300 = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       c_in = 1'b0;

    logic       a8, b8, c8, busy8, done8, ovf8;
    logic [1:0] mode8, state8;
    logic [7:0] cin8, cout8, count8;
    logic       a3, b3, c3, busy3, done3, ovf3;
    logic [1:0] mode3, state3;
    logic [7:0] cin3, cout3, count3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q8[$];
    exp_t exp_q3[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural COUNT: increments when gated on and the mode rule holds.
    function automatic logic [7:0] count_model(input logic [1:0] m, input logic a, input logic b,
                                               input logic c, input logic [1:0] st,
                                               input logic [7:0] cin);
        logic hit;
        case (m)
            2'b00:   hit = a;
            2'b01:   hit = a & b;
            2'b10:   hit = a ^ b;
            default: hit = ({a, b, c} == 3'b011) || ({a, b, c} == 3'b101) || ({a, b, c} == 3'b110);
        endcase
        return (st == 2'b01 && hit) ? cin + 8'd1 : cin;
    endfunction

    assign cout8 = count_model(mode8, a8, b8, c8, state8, cin8);
    assign cout3 = count_model(mode3, a3, b3, c3, state3, cin3);

    count_sequencer #(.WINDOW(8), .WCNT_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .pause(pause), .abort(abort),
        .mode_sel(mode_sel), .A_in(a_in), .B_in(b_in), .C_in(c_in),
        .A(a8), .B(b8), .C(c8), .mode(mode8), .state(state8), .CountIn(cin8),
        .CountOut(cout8), .count(count8), .busy(busy8), .done(done8), .ovf(ovf8)
    );

    count_sequencer #(.WINDOW(300), .WCNT_W(16)) u_dut300 (
        .clk(clk), .rst(rst), .start(start300), .pause(pause), .abort(abort),
        .mode_sel(mode_sel), .A_in(a_in), .B_in(b_in), .C_in(c_in),
        .A(a3), .B(b3), .C(c3), .mode(mode3), .state(state3), .CountIn(cin3),
        .CountOut(cout3), .count(count3), .busy(busy3), .done(done3), .ovf(ovf3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitors: each rising done pops the next expected result.
    logic done8_prev = 1'b0;
    logic done3_prev = 1'b0;
    exp_t e8, e3;

    always @(negedge clk) begin
        if (done8 && !done8_prev) begin
            if (exp_q8.size() == 0) begin
                chk("dut8_unexpected_done", 32'(1), 32'(0));
            end else begin
                e8 = exp_q8.pop_front();
                chk("dut8_count", 32'(count8), 32'(e8.cnt));
                chk("dut8_ovf", 32'(ovf8), 32'(e8.ovf));
                chk("dut8_done_cycle", 32'(cyc), e8.done_cyc);
            end
        end
        done8_prev = done8;
    end

    always @(negedge clk) begin
        if (done3 && !done3_prev) begin
            if (exp_q3.size() == 0) begin
                chk("dut300_unexpected_done", 32'(1), 32'(0));
            end else begin
                e3 = exp_q3.pop_front();
                chk("dut300_count", 32'(count3), 32'(e3.cnt));
                chk("dut300_ovf", 32'(ovf3), 32'(e3.ovf));
                chk("dut300_done_cycle", 32'(cyc), e3.done_cyc);
            end
        end
        done3_prev = done3;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WINDOW=8 measurement; pats holds up to four {A,B,C} patterns, cycle k uses k % plen.
    task automatic run8(input string name, input logic [1:0] m, input logic [11:0] pats,
                        input int plen, input int p_lo, input int p_hi,
                        input logic [7:0] exp_cnt, input int exp_lat);
        int   c0;
        logic seen;
        logic busy_ok;
        logic pstate_ok;
        logic [11:0] pv;
        seen = 1'b0;
        busy_ok = 1'b1;
        pstate_ok = 1'b1;
        pv = pats;
        c0 = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (k == 0) begin
                c0 = cyc;
                exp_q8.push_back('{cnt: exp_cnt, ovf: 1'b0, done_cyc: 32'(c0 + exp_lat)});
            end
            start8   = (k == 0);
            mode_sel = m;
            {a_in, b_in, c_in} = pv[3*(k % plen) +: 3];
            pause = (k >= p_lo) && (k <= p_hi);
            @(negedge clk);
            if (k == 1) chk({name, "_state_run"}, 32'(state8), 32'(2'b01));
            if (k >= 1 && !done8) busy_ok = busy_ok & busy8;
            if (k >= 1 && pause) pstate_ok = pstate_ok & (state8 == 2'b00);
            if (k >= 1 && done8) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'(1));
        chk({name, "_busy_held"}, 32'(busy_ok), 32'(1));
        if (p_lo >= 0) chk({name, "_state_paused"}, 32'(pstate_ok), 32'(1));
        chk({name, "_state_done"}, 32'(state8), 32'(2'b00));
        step();
        start8 = 1'b0;
        pause  = 1'b0;
        {a_in, b_in, c_in} = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic seen;
        // Reset with pins and mode_sel busy so zero outputs are meaningful.
        rst = 1'b1;
        a_in = 1'b1;
        mode_sel = 2'b11;
        repeat (3) step();
        @(negedge clk);
        chk("rst_A", 32'(a8), 32'(0));
        chk("rst_mode", 32'(mode8), 32'(0));
        chk("rst_count", 32'(count8), 32'(0));
        chk("rst_busy", 32'(busy8), 32'(0));
        chk("rst_done", 32'(done8), 32'(0));
        chk("rst_ovf", 32'(ovf8), 32'(0));
        chk("rst_state", 32'(state8), 32'(0));
        step();
        rst = 1'b0;
        a_in = 1'b0;
        mode_sel = 2'b00;
        step();

        // Start-to-done latency is WINDOW+1, plus 4 lost cycles for a 3-cycle pause.
        run8("m00",   2'b00, 12'b000_000_000_100, 1, -1, -1, 8'd8, 9);
        run8("m01",   2'b01, 12'b000_000_100_110, 2, -1, -1, 8'd4, 9);
        run8("m10",   2'b10, 12'b000_000_000_100, 1, -1, -1, 8'd8, 9);
        run8("m11",   2'b11, 12'b110_001_111_011, 4, -1, -1, 8'd4, 9);
        run8("pause", 2'b00, 12'b000_000_000_100, 1,  3,  5, 8'd8, 13);

        // Abort together with start in the middle of a run.
        step(); start8 = 1'b1; mode_sel = 2'b00; a_in = 1'b1;
        step(); start8 = 1'b0;
        step();
        step(); abort = 1'b1; start8 = 1'b1;
        @(negedge clk);
        chk("abort_pre_count", 32'(count8), 32'(2));
        chk("abort_state_gate", 32'(state8), 32'(0));
        step(); abort = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("abort_count", 32'(count8), 32'(0));
        chk("abort_done", 32'(done8), 32'(0));
        chk("abort_busy", 32'(busy8), 32'(0));

        // Saturation on the WINDOW=300 instance: wraps at the 256th active cycle.
        seen = 1'b0;
        step(); start300 = 1'b1; mode_sel = 2'b00; a_in = 1'b1;
        c0 = cyc;
        exp_q3.push_back('{cnt: 8'd255, ovf: 1'b1, done_cyc: 32'(c0 + 257)});
        step(); start300 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done3) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("ovf_done_seen", 32'(seen), 32'(1));
        step(); start300 = 1'b1;
        step(); start300 = 1'b0;
        @(negedge clk);
        chk("restart_count", 32'(count3), 32'(0));
        chk("restart_ovf", 32'(ovf3), 32'(0));
        chk("restart_busy", 32'(busy3), 32'(1));
        step(); abort = 1'b1;
        step(); abort = 1'b0; a_in = 1'b0;

        // Reset in the middle of a mode-10 run.
        step(); start8 = 1'b1; mode_sel = 2'b10; a_in = 1'b1;
        step(); start8 = 1'b0;
        step();
        @(negedge clk);
        chk("midrst_pre_mode", 32'(mode8), 32'(2'b10));
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("midrst_A", 32'(a8), 32'(0));
        chk("midrst_mode", 32'(mode8), 32'(0));
        chk("midrst_count", 32'(count8), 32'(0));
        chk("midrst_busy", 32'(busy8), 32'(0));
        chk("midrst_done", 32'(done8), 32'(0));
        chk("midrst_ovf", 32'(ovf8), 32'(0));
        chk("midrst_state", 32'(state8), 32'(0));
        a_in = 1'b0;

        repeat (3) step();
        chk("sb8_drained", 32'(exp_q8.size()), 32'(0));
        chk("sb300_drained", 32'(exp_q3.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
